clock_set_ctrl: RTL

Mode/sequencing controller for the digital clock time counters (seconds, minutes, hours).
- Generates the 1 Hz count tick.
- Runs the set-time state machine from two push-buttons, issuing load strobes plus load data to the counter selected for setting.
- Drives the one-hot bus enables that share the display databus between the three counters.
- Sits between the button inputs and the counter bank.

---
 rtl/clock_set_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// Set-time sequencer for the digital clock: 1 Hz tick, button-driven
// load strobes for the time counters, and the one-hot display bus select.
module clock_set_ctrl #(
   parameter int TICK_DIV = 50000000,
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       clear_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [5:0] sec_in,
   input  logic [5:0] min_in,
   input  logic [4:0] hour_in,
   output logic       tick,
   output logic       sec_ld,
   output logic       min_ld,
   output logic       hour_ld,
   output logic [5:0] ld_data,
   output logic [2:0] bus_en,
   output logic [1:0] mode
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      SET_H = 2'b01,
      SET_M = 2'b10,
      SET_S = 2'b11
   } state_t;

   state_t state_q, state_d;
   logic [2:0] mode_sy_q;
   logic [2:0] inc_sy_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [SW-1:0] scan_q, scan_d;
   logic tick_q, tick_d;
   logic sec_ld_q, sec_ld_d;
   logic min_ld_q, min_ld_d;
   logic hour_ld_q, hour_ld_d;
   logic [5:0] ld_data_q, ld_data_d;
   logic [2:0] bus_q, bus_d;

   logic mode_p;
   logic inc_p;
   logic [5:0] h6;
   logic [5:0] h_nxt;
   logic [5:0] m_nxt;
   logic [5:0] s_nxt;

   // bits [1:0] synchronize, bit 2 remembers the previous level
   assign mode_p = mode_sy_q[1] & ~mode_sy_q[2];
   assign inc_p  = inc_sy_q[1] & ~inc_sy_q[2];

   assign h6    = {1'b0, hour_in};
   assign h_nxt = (h6 >= 6'd23) ? 6'd0 : h6 + 6'd1;
   assign m_nxt = (min_in >= 6'd59) ? 6'd0 : min_in + 6'd1;
   assign s_nxt = (sec_in >= 6'd59) ? 6'd0 : sec_in + 6'd1;

   always_comb begin
      state_d = state_q;
      if (mode_p) begin
         unique case (state_q)
            RUN:   state_d = SET_H;
            SET_H: state_d = SET_M;
            SET_M: state_d = SET_S;
            SET_S: state_d = RUN;
         endcase
      end
   end

   // a mode edge in the same cycle swallows the increment
   always_comb begin
      sec_ld_d  = 1'b0;
      min_ld_d  = 1'b0;
      hour_ld_d = 1'b0;
      ld_data_d = 6'd0;
      if (inc_p && !mode_p) begin
         unique case (state_q)
            RUN: ;
            SET_H: begin
               hour_ld_d = 1'b1;
               ld_data_d = h_nxt;
            end
            SET_M: begin
               min_ld_d  = 1'b1;
               ld_data_d = m_nxt;
            end
            SET_S: begin
               sec_ld_d  = 1'b1;
               ld_data_d = s_nxt;
            end
         endcase
      end
   end

   always_comb begin
      presc_d = '0;
      tick_d  = 1'b0;
      if (state_q == RUN && state_d == RUN) begin
         tick_d = (presc_q == PMAX);
         if (presc_q == PMAX) begin
            presc_d = '0;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_comb begin
      scan_d = '0;
      bus_d  = 3'b001;
      if (state_d == RUN) begin
         if (state_q != RUN) begin
            bus_d = 3'b001;
         end else if (scan_q == SMAX) begin
            bus_d = {bus_q[1:0], bus_q[2]};
         end else begin
            scan_d = scan_q + SW'(1);
            bus_d  = bus_q;
         end
      end else begin
         unique case (state_d)
            RUN:   bus_d = 3'b001;
            SET_H: bus_d = 3'b100;
            SET_M: bus_d = 3'b010;
            SET_S: bus_d = 3'b001;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= RUN;
         mode_sy_q <= 3'b000;
         inc_sy_q  <= 3'b000;
         presc_q   <= '0;
         scan_q    <= '0;
         tick_q    <= 1'b0;
         sec_ld_q  <= 1'b0;
         min_ld_q  <= 1'b0;
         hour_ld_q <= 1'b0;
         ld_data_q <= 6'd0;
         bus_q     <= 3'b001;
      end else begin
         state_q   <= state_d;
         mode_sy_q <= {mode_sy_q[1:0], btn_mode};
         inc_sy_q  <= {inc_sy_q[1:0], btn_inc};
         presc_q   <= presc_d;
         scan_q    <= scan_d;
         tick_q    <= tick_d;
         sec_ld_q  <= sec_ld_d;
         min_ld_q  <= min_ld_d;
         hour_ld_q <= hour_ld_d;
         ld_data_q <= ld_data_d;
         bus_q     <= bus_d;
      end
   end

   assign tick    = tick_q;
   assign sec_ld  = sec_ld_q;
   assign min_ld  = min_ld_q;
   assign hour_ld = hour_ld_q;
   assign ld_data = ld_data_q;
   assign bus_en  = bus_q;
   assign mode    = state_q;

endmodule
